// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 UART transmitter with a small byte FIFO in front of the
//               serial line. Frames are 1 start bit (0), 8 data bits LSB
//               first and 1 stop bit (1). Back-to-back bytes are sent with no
//               idle gap between a stop bit and the next start bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int DIV_CNT    = 867,   // clocks per bit minus 1, >= 1
    parameter int FIFO_DEPTH = 4      // power of 2, >= 2
) (
    input  logic                          clk,
    input  logic                          rst,        // async, active low
    input  logic                          dout_vld,
    input  logic [7:0]                    dout_data,
    output logic                          dout_rdy,
    output logic                          dout,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_DIV_W = $clog2(DIV_CNT + 1);

    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(DIV_CNT);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_EMPTY   = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_cnt;

    state_t              r_state;
    logic [c_DIV_W-1:0]  r_div;
    logic [2:0]          r_bit;
    logic [7:0]          r_sh;
    logic                r_dout;

    // ------------------------------------------------------------------------
    // Combinational next-state values
    // ------------------------------------------------------------------------
    state_t              w_state_nxt;
    logic [c_DIV_W-1:0]  w_div_nxt;
    logic [2:0]          w_bit_nxt;
    logic [7:0]          w_sh_nxt;
    logic                w_dout_nxt;
    logic                w_pop;
    logic                w_push;
    logic                w_full;
    logic                w_has_data;
    logic                w_div_end;
    logic [7:0]          w_head;

    // FIFO status is decoded from registered occupancy only, so dout_rdy
    // never depends on a pop happening on the same edge.
    assign w_full     = (r_cnt == c_FULL);
    assign w_has_data = (r_cnt != c_EMPTY);
    assign w_push     = dout_vld && !w_full;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_div_end  = (r_div == c_DIV_MAX);

    assign dout_rdy   = !w_full;
    assign dout       = r_dout;
    assign fifo_cnt   = r_cnt;
    assign tx_busy    = (r_state != S_IDLE) || w_has_data;

    // FIFO storage: data only, no reset needed since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= dout_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Transmit state register; reset returns the line high at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
            r_dout  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_sh    <= w_sh_nxt;
            r_dout  <= w_dout_nxt;
        end
    end

    // Frame sequencing: bit timing, shifting and FIFO pops.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div + 1'b1;
        w_bit_nxt   = r_bit;
        w_sh_nxt    = r_sh;
        w_dout_nxt  = r_dout;
        w_pop       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_dout_nxt = 1'b1;
                w_div_nxt  = '0;
                if (w_has_data) begin
                    w_pop       = 1'b1;
                    w_sh_nxt    = w_head;
                    w_state_nxt = S_START;
                    w_dout_nxt  = 1'b0;
                end
            end
            S_START: begin
                if (w_div_end) begin
                    w_div_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_dout_nxt  = r_sh[0];
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_div_end) begin
                    w_div_nxt = '0;
                    if (r_bit != 3'd7) begin
                        // dout currently carries r_sh[0]; the next bit is r_sh[1].
                        w_sh_nxt   = {1'b0, r_sh[7:1]};
                        w_dout_nxt = r_sh[1];
                        w_bit_nxt  = r_bit + 3'd1;
                    end else begin
                        w_dout_nxt  = 1'b1;
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_div_end) begin
                    w_div_nxt = '0;
                    if (w_has_data) begin
                        // Chain straight into the next start bit, no idle gap.
                        w_pop       = 1'b1;
                        w_sh_nxt    = w_head;
                        w_dout_nxt  = 1'b0;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_div_nxt   = '0;
                w_dout_nxt  = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx. A frame-timeline model
//               predicts the line, occupancy and busy flags every cycle; a
//               line decoder checks byte order; directed tests add literal
//               expectations for framing, overflow, push/pop and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int DIV   = 7;
    localparam int BIT   = DIV + 1;
    localparam int FRAME = 10 * BIT;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dout_vld = 1'b0;
    logic [7:0] dout_data = 8'h00;
    logic       dout_rdy, dout, tx_busy;
    logic [2:0] fifo_cnt;

    logic       vld_d = 1'b0;
    logic [7:0] data_d = 8'h00;
    logic       rdy_d, dout_d, busy_d;
    logic [2:0] cnt_d;

    int n_vec = 0;
    int n_err = 0;
    bit en    = 1'b0;

    always #5 clk = ~clk;

    uart_tx #(.DIV_CNT(DIV), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .dout_vld(dout_vld), .dout_data(dout_data),
        .dout_rdy(dout_rdy), .dout(dout), .tx_busy(tx_busy), .fifo_cnt(fifo_cnt)
    );

    uart_tx #(.DIV_CNT(867), .FIFO_DEPTH(4)) u_def (
        .clk(clk), .rst(rst), .dout_vld(vld_d), .dout_data(data_d),
        .dout_rdy(rdy_d), .dout(dout_d), .tx_busy(busy_d), .fifo_cnt(cnt_d)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: queue + frame timeline ------------
    logic [7:0] mq[$];
    logic [7:0] m_started[$];
    int         m_pos  = -1;     // clock index inside current frame, -1 idle
    logic [7:0] m_byte = 8'h00;
    int         m_pre;
    bit         m_acc;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_started.delete();
            m_pos = -1;
        end else begin
            m_pre = mq.size();
            m_acc = dout_vld && (m_pre < DEPTH);
            if (m_pos < 0) begin
                if (m_pre > 0) begin
                    m_byte = mq.pop_front();
                    m_started.push_back(m_byte);
                    m_pos = 0;
                end
            end else begin
                m_pos++;
                if (m_pos == FRAME) begin
                    if (m_pre > 0) begin
                        m_byte = mq.pop_front();
                        m_started.push_back(m_byte);
                        m_pos = 0;
                    end else begin
                        m_pos = -1;
                    end
                end
            end
            if (m_acc) mq.push_back(dout_data);
        end
    end

    function automatic logic exp_dout();
        int b;
        if (m_pos < 0) return 1'b1;
        b = m_pos / BIT;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_byte[b-1];
        return 1'b1;
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (en) begin
            chk("dout", {31'd0, dout}, {31'd0, exp_dout()});
            chk("fifo_cnt", {29'd0, fifo_cnt}, mq.size());
            chk("tx_busy", {31'd0, tx_busy}, {31'd0, (m_pos >= 0) || (mq.size() != 0)});
            chk("dout_rdy", {31'd0, dout_rdy}, {31'd0, mq.size() != DEPTH});
        end
    end

    // ---------------- line decoder on the fast instance --------------------
    bit         rx_on = 1'b0;
    int         rx_t  = 0;
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rx_log[$];
    logic [7:0] rx_exp;

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (en && dout == 1'b0) begin
                rx_on = 1'b1;
                rx_t  = 0;
            end
        end else begin
            rx_t++;
            if (rx_t == BIT/2) chk("rx start bit", {31'd0, dout}, 0);
            if (rx_t % BIT == BIT/2 && rx_t / BIT >= 1 && rx_t / BIT <= 8)
                rx_sh[rx_t/BIT - 1] = dout;
            if (rx_t == 9*BIT + BIT/2) begin
                chk("rx stop bit", {31'd0, dout}, 1);
                chk("rx frames pending", m_started.size(), 1);
                rx_exp = (m_started.size() > 0) ? m_started.pop_front() : 8'hXX;
                chk("rx byte order", {24'd0, rx_sh}, {24'd0, rx_exp});
                rx_log.push_back(rx_sh);
            end
            if (rx_t == FRAME - 1) rx_on = 1'b0;
        end
    end

    logic [7:0] exp_arr[5];

    task automatic check_rx(input string nm, input int n);
        chk({nm, " frame count"}, rx_log.size(), n);
        for (int i = 0; i < n; i++)
            if (i < rx_log.size()) chk({nm, " byte"}, {24'd0, rx_log[i]}, {24'd0, exp_arr[i]});
        rx_log.delete();
    endtask

    // Decode one frame from the default-rate instance, sampling mid-bit.
    task automatic rx_def(input logic [7:0] exp_b);
        int t;
        logic [7:0] b;
        t = 0;
        while (dout_d !== 1'b0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (dout_d !== 1'b0) begin
            chk("loopback start timeout", {31'd0, dout_d}, 0);
            return;
        end
        repeat (434) @(negedge clk);
        chk("loopback start bit", {31'd0, dout_d}, 0);
        for (int i = 0; i < 8; i++) begin
            repeat (868) @(negedge clk);
            b[i] = dout_d;
        end
        repeat (868) @(negedge clk);
        chk("loopback stop bit", {31'd0, dout_d}, 1);
        chk("loopback byte", {24'd0, b}, {24'd0, exp_b});
    endtask

    logic [9:0] hand_frame;
    logic [7:0] t2_bytes[4];
    logic [7:0] lb_bytes[4];

    initial begin
        // ---------------- reset ----------------
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset dout", {31'd0, dout}, 1);
        chk("reset fifo_cnt", {29'd0, fifo_cnt}, 0);
        chk("reset tx_busy", {31'd0, tx_busy}, 0);
        chk("reset dout_rdy", {31'd0, dout_rdy}, 1);
        rst = 1'b1;
        en  = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- 1: single byte 0xA3 ----------------
        hand_frame = 10'b1_1010_0011_0;
        dout_data = 8'hA3; dout_vld = 1'b1;
        @(negedge clk);
        dout_vld = 1'b0;
        chk("t1 cnt after write", {29'd0, fifo_cnt}, 1);
        chk("t1 line still idle", {31'd0, dout}, 1);
        for (int k = 2; k <= 90; k++) begin
            @(negedge clk);
            if (k == 2) chk("t1 start edge", {31'd0, dout}, 0);
            if (k <= 81 && (k - 2) % BIT == BIT/2)
                chk("t1 frame bit", {31'd0, dout}, {31'd0, hand_frame[(k-2)/BIT]});
            if (k == 81) chk("t1 busy last clock", {31'd0, tx_busy}, 1);
            if (k == 82) chk("t1 busy dropped", {31'd0, tx_busy}, 0);
        end
        exp_arr = '{8'hA3, 8'h00, 8'h00, 8'h00, 8'h00};
        check_rx("t1", 1);

        // ---------------- 2: back-to-back ----------------
        t2_bytes = '{8'h00, 8'hFF, 8'h5A, 8'h81};
        for (int i = 0; i < 4; i++) begin
            dout_data = t2_bytes[i]; dout_vld = 1'b1;
            @(negedge clk);
        end
        dout_vld = 1'b0;
        repeat (340) @(negedge clk);
        exp_arr = '{8'h00, 8'hFF, 8'h5A, 8'h81, 8'h00};
        check_rx("t2", 4);

        // ---------------- 3: full / overflow ----------------
        for (int i = 0; i < 6; i++) begin
            dout_data = 8'h10 + 8'(i); dout_vld = 1'b1;
            @(negedge clk);
            if (i == 4) begin
                chk("t3 full count", {29'd0, fifo_cnt}, 4);
                chk("t3 rdy low", {31'd0, dout_rdy}, 0);
            end
            if (i == 5) chk("t3 drop keeps count", {29'd0, fifo_cnt}, 4);
        end
        dout_vld = 1'b0;
        repeat (420) @(negedge clk);
        exp_arr = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        check_rx("t3", 5);

        // ---------------- 4: push and pop on the same edge ----------------
        dout_data = 8'hC3; dout_vld = 1'b1; @(negedge clk);
        dout_data = 8'h3C;                  @(negedge clk);
        dout_data = 8'h96;                  @(negedge clk);
        dout_vld = 1'b0;
        repeat (78) @(negedge clk);
        chk("t4 cnt before", {29'd0, fifo_cnt}, 2);
        chk("t4 in stop bit", {31'd0, dout}, 1);
        dout_data = 8'h69; dout_vld = 1'b1;
        @(negedge clk);
        dout_vld = 1'b0;
        chk("t4 cnt after", {29'd0, fifo_cnt}, 2);
        chk("t4 next start", {31'd0, dout}, 0);
        repeat (260) @(negedge clk);
        exp_arr = '{8'hC3, 8'h3C, 8'h96, 8'h69, 8'h00};
        check_rx("t4", 4);

        // ---------------- 5: asynchronous reset mid-frame ----------------
        dout_data = 8'h0F; dout_vld = 1'b1; @(negedge clk);
        dout_data = 8'h33;                  @(negedge clk);
        dout_data = 8'h44;                  @(negedge clk);
        dout_vld = 1'b0;
        repeat (41) @(negedge clk);
        chk("t5 data bit 4 low", {31'd0, dout}, 0);
        #2 rst = 1'b0;
        #1;
        chk("t5 async dout", {31'd0, dout}, 1);
        chk("t5 async cnt", {29'd0, fifo_cnt}, 0);
        chk("t5 async busy", {31'd0, tx_busy}, 0);
        chk("t5 async rdy", {31'd0, dout_rdy}, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (200) @(negedge clk);
        chk("t5 line stays high", {31'd0, dout}, 1);
        chk("t5 stays idle", {31'd0, tx_busy}, 0);
        check_rx("t5", 0);

        // ---------------- 6: loopback at default rate ----------------
        lb_bytes = '{8'h00, 8'h55, 8'hAA, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            data_d = lb_bytes[i]; vld_d = 1'b1;
            @(negedge clk);
        end
        vld_d = 1'b0;
        for (int i = 0; i < 4; i++) rx_def(lb_bytes[i]);
        repeat (900) @(negedge clk);
        chk("t6 idle after loopback", {31'd0, busy_d}, 0);
        chk("t6 fifo drained", {29'd0, cnt_d}, 0);
        chk("t6 rdy after loopback", {31'd0, rdy_d}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
